// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one Dcache request port between masters M0 and M1.
// Read data is steered back to its issuer by an owner-tag pipeline RD_LAT stages deep.
module dcache_port_arbiter #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_wsel,
    output logic          m0_gnt,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_wsel,
    output logic          m1_gnt,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    input  logic          dcache_stall_i,
    input  logic [DW-1:0] dcache_data_i,
    output logic [AW-1:0] dcache_raddr_o,
    output logic [AW-1:0] dcache_waddr_o,
    output logic [DW-1:0] dcache_wdata_o,
    output logic          dcache_wreq_o,
    output logic          dcache_rreq_o,
    output logic [3:0]    dcache_wsel_o
);

    if (RD_LAT == 0) begin : g_bad_rd_lat
        $error("dcache_port_arbiter: RD_LAT must be at least 1");
    end

    logic              r_last_gnt;
    logic              r_owner;
    logic [AW-1:0]     r_raddr;
    logic [AW-1:0]     r_waddr;
    logic [DW-1:0]     r_wdata;
    logic [3:0]        r_wsel;
    logic              r_wreq;
    logic              r_rreq;
    logic [RD_LAT-1:0] r_tag_v;
    logic [RD_LAT-1:0] r_tag_o;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    logic              w_sel_we;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic [3:0]        w_sel_wsel;

    // Under contention the master that did not win last time gets the port.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst && !dcache_stall_i) begin
            if (m0_req && m1_req) begin
                w_gnt0 = r_last_gnt;
                w_gnt1 = !r_last_gnt;
            end else begin
                w_gnt0 = m0_req;
                w_gnt1 = m1_req;
            end
        end
    end

    assign w_any_gnt   = w_gnt0 | w_gnt1;
    assign w_sel_we    = w_gnt1 ? m1_we    : m0_we;
    assign w_sel_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;
    assign w_sel_wsel  = w_gnt1 ? m1_wsel  : m0_wsel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_gnt <= 1'b1;
            r_owner    <= 1'b0;
            r_raddr    <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_wsel     <= '0;
            r_wreq     <= 1'b0;
            r_rreq     <= 1'b0;
            r_tag_v    <= '0;
            r_tag_o    <= '0;
        end else if (!dcache_stall_i) begin
            // Stage 0 captures the strobe currently on the port; the last stage lines up
            // with the cycle the cache returns its data.
            r_tag_v <= (r_tag_v << 1) | RD_LAT'(r_rreq);
            r_tag_o <= (r_tag_o << 1) | RD_LAT'(r_owner);
            r_wreq  <= 1'b0;
            r_rreq  <= 1'b0;
            if (w_any_gnt) begin
                r_last_gnt <= w_gnt1;
                r_owner    <= w_gnt1;
                if (w_sel_we) begin
                    r_waddr <= w_sel_addr;
                    r_wdata <= w_sel_wdata;
                    r_wsel  <= w_sel_wsel;
                    r_wreq  <= 1'b1;
                end else begin
                    r_raddr <= w_sel_addr;
                    r_rreq  <= 1'b1;
                end
            end
        end
    end

    assign m0_gnt         = w_gnt0;
    assign m1_gnt         = w_gnt1;
    assign m0_rdata       = dcache_data_i;
    assign m1_rdata       = dcache_data_i;
    assign m0_rvalid      = r_tag_v[RD_LAT-1] && !r_tag_o[RD_LAT-1];
    assign m1_rvalid      = r_tag_v[RD_LAT-1] && r_tag_o[RD_LAT-1];
    assign dcache_raddr_o = r_raddr;
    assign dcache_waddr_o = r_waddr;
    assign dcache_wdata_o = r_wdata;
    assign dcache_wsel_o  = r_wsel;
    assign dcache_wreq_o  = r_wreq;
    assign dcache_rreq_o  = r_rreq;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share one stimulus,
// each backed by a small cache model whose read pipeline freezes while stalled.
module tb_dcache_port_arbiter;

    typedef struct packed {
        int          d;
        int          c;
        int          m;
        logic [31:0] v;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        m_req   [2];
    logic        m_we    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wsel  [2];

    logic        gnt_a   [2][2];
    logic        rv_a    [2][2];
    logic [31:0] rd_a    [2][2];
    logic [31:0] raddr_a [2];
    logic [31:0] waddr_a [2];
    logic [31:0] wdata_a [2];
    logic [3:0]  wsel_a  [2];
    logic        wreq_a  [2];
    logic        rreq_a  [2];
    logic [31:0] cdata_a [2];

    logic [31:0] ref_mem [16];
    ev_t         rv_q [$];
    int          wreq_cnt [2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : 3;
        logic [31:0] mem   [16];
        logic [31:0] dpipe [Lat];

        dcache_port_arbiter #(.AW(32), .DW(32), .RD_LAT(Lat)) u_dut (
            .clk(clk), .rst(rst),
            .m0_req(m_req[0]), .m0_we(m_we[0]), .m0_addr(m_addr[0]),
            .m0_wdata(m_wdata[0]), .m0_wsel(m_wsel[0]), .m0_gnt(gnt_a[g][0]),
            .m0_rdata(rd_a[g][0]), .m0_rvalid(rv_a[g][0]),
            .m1_req(m_req[1]), .m1_we(m_we[1]), .m1_addr(m_addr[1]),
            .m1_wdata(m_wdata[1]), .m1_wsel(m_wsel[1]), .m1_gnt(gnt_a[g][1]),
            .m1_rdata(rd_a[g][1]), .m1_rvalid(rv_a[g][1]),
            .dcache_stall_i(stall), .dcache_data_i(cdata_a[g]),
            .dcache_raddr_o(raddr_a[g]), .dcache_waddr_o(waddr_a[g]),
            .dcache_wdata_o(wdata_a[g]), .dcache_wreq_o(wreq_a[g]),
            .dcache_rreq_o(rreq_a[g]), .dcache_wsel_o(wsel_a[g])
        );

        always @(posedge clk) begin
            if (!stall) begin
                if (wreq_a[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wsel_a[g][b]) mem[waddr_a[g][5:2]][8*b +: 8] <= wdata_a[g][8*b +: 8];
                    end
                end
                dpipe[0] <= rreq_a[g] ? mem[raddr_a[g][5:2]] : 32'hDEAD_0000;
                for (int i = 1; i < Lat; i++) dpipe[i] <= dpipe[i-1];
            end
        end
        assign cdata_a[g] = dpipe[Lat-1];
    end

    // Event log only; all judgement happens in the test tasks.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                if (rv_a[d][m] === 1'b1) begin
                    ev_t e;
                    e.d = d;
                    e.c = cyc;
                    e.m = m;
                    e.v = rd_a[d][m];
                    rv_q.push_back(e);
                end
            end
            if (wreq_a[d] === 1'b1 && stall === 1'b0) wreq_cnt[d] = wreq_cnt[d] + 1;
        end
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic pulse_reset();
        rst      = 1'b0;
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        stall    = 1'b0;
        next_cycle();
        rst = 1'b1;
        rv_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        stall = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_req[m] = 1'b1; m_we[m] = 1'b0; m_addr[m] = 32'h40 + 4 * m;
            m_wdata[m] = 32'h0; m_wsel[m] = 4'h0;
        end
        repeat (3) begin
            next_cycle();
            sample();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({gnt_a[d][0], gnt_a[d][1]} !== 2'b00) begin
                    errors++;
                    $display("FAIL reset_gnt dut%0d: got %b want 00", d, {gnt_a[d][0], gnt_a[d][1]});
                end
                checks++;
                if ({wreq_a[d], rreq_a[d]} !== 2'b00) begin
                    errors++;
                    $display("FAIL reset_strobe dut%0d: got %b want 00", d, {wreq_a[d], rreq_a[d]});
                end
                checks++;
                if ({raddr_a[d], waddr_a[d], wdata_a[d], wsel_a[d]} !== 100'h0) begin
                    errors++;
                    $display("FAIL reset_regs dut%0d: got %h %h %h %h want all 0", d,
                             raddr_a[d], waddr_a[d], wdata_a[d], wsel_a[d]);
                end
                checks++;
                if ({rv_a[d][0], rv_a[d][1]} !== 2'b00) begin
                    errors++;
                    $display("FAIL reset_rvalid dut%0d: got %b want 00", d, {rv_a[d][0], rv_a[d][1]});
                end
            end
        end
        next_cycle();
        rst = 1'b1;
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        next_cycle();
        rv_q.delete();
    endtask

    task automatic test_single_master();
        int          exp_c [16];
        logic [31:0] exp_d [16];
        int          base_w [2];
        ev_t         exp_e;
        base_w[0] = wreq_cnt[0];
        base_w[1] = wreq_cnt[1];
        for (int i = 0; i < 16; i++) begin
            m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 32'(4 * i);
            m_wdata[0] = $urandom; m_wsel[0] = 4'hF;
            ref_mem[i] = m_wdata[0];
            sample();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({gnt_a[d][0], gnt_a[d][1]} !== 2'b10) begin
                    errors++;
                    $display("FAIL single_wr_gnt dut%0d i%0d: got %b want 10", d, i,
                             {gnt_a[d][0], gnt_a[d][1]});
                end
                if (i > 0) begin
                    checks++;
                    if ({wreq_a[d], rreq_a[d], waddr_a[d], wdata_a[d]} !==
                        {2'b10, 32'(4 * (i - 1)), ref_mem[i-1]}) begin
                        errors++;
                        $display("FAIL single_wr_strobe dut%0d i%0d: got w%b r%b a%h d%h want w1 r0 a%h d%h",
                                 d, i, wreq_a[d], rreq_a[d], waddr_a[d], wdata_a[d],
                                 32'(4 * (i - 1)), ref_mem[i-1]);
                    end
                end
            end
            next_cycle();
        end
        m_req[0] = 1'b0;
        sample();
        next_cycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (wreq_cnt[d] - base_w[d] != 16) begin
                errors++;
                $display("FAIL single_wr_count dut%0d: got %0d want 16", d, wreq_cnt[d] - base_w[d]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            int a;
            a = $urandom_range(0, 15);
            m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'(4 * a);
            sample();
            exp_c[i] = cyc;
            exp_d[i] = ref_mem[a];
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({gnt_a[d][0], gnt_a[d][1]} !== 2'b10) begin
                    errors++;
                    $display("FAIL single_rd_gnt dut%0d i%0d: got %b want 10", d, i,
                             {gnt_a[d][0], gnt_a[d][1]});
                end
            end
            next_cycle();
        end
        idle(6);
        for (int d = 0; d < 2; d++) begin
            int n;
            n = 0;
            foreach (rv_q[k]) begin
                if (rv_q[k].d == d) begin
                    if (n < 16) begin
                        exp_e.d = d; exp_e.c = exp_c[n] + 1 + lat_of(d); exp_e.m = 0; exp_e.v = exp_d[n];
                        checks++;
                        if (rv_q[k] !== exp_e) begin
                            errors++;
                            $display("FAIL single_rd dut%0d #%0d: got c%0d m%0d v%h want c%0d m0 v%h",
                                     d, n, rv_q[k].c, rv_q[k].m, rv_q[k].v, exp_e.c, exp_e.v);
                        end
                    end
                    n++;
                end
            end
            checks++;
            if (n != 16) begin
                errors++;
                $display("FAIL single_rd_count dut%0d: got %0d want 16", d, n);
            end
        end
    endtask

    task automatic test_contention();
        int          lst [2][4] = '{'{3, 7, 11, 15}, '{12, 1, 9, 5}};
        int          idx [2] = '{0, 0};
        int          exp_c [8];
        logic [31:0] exp_d [8];
        ev_t         exp_e;
        pulse_reset();
        for (int j = 0; j < 8; j++) begin
            int w;
            w = j % 2;
            for (int m = 0; m < 2; m++) begin
                m_req[m] = 1'b1; m_we[m] = 1'b0; m_addr[m] = 32'(4 * lst[m][idx[m]]);
            end
            sample();
            exp_c[j] = cyc;
            exp_d[j] = ref_mem[lst[w][idx[w]]];
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({gnt_a[d][0], gnt_a[d][1]} !== ((w == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL contend_gnt dut%0d j%0d: got %b want %b", d, j,
                             {gnt_a[d][0], gnt_a[d][1]}, (w == 0) ? 2'b10 : 2'b01);
                end
            end
            idx[w] = idx[w] + 1;
            next_cycle();
        end
        idle(6);
        for (int d = 0; d < 2; d++) begin
            int n;
            n = 0;
            foreach (rv_q[k]) begin
                if (rv_q[k].d == d) begin
                    if (n < 8) begin
                        exp_e.d = d; exp_e.c = exp_c[n] + 1 + lat_of(d); exp_e.m = n % 2;
                        exp_e.v = exp_d[n];
                        checks++;
                        if (rv_q[k] !== exp_e) begin
                            errors++;
                            $display("FAIL contend_rd dut%0d #%0d: got c%0d m%0d v%h want c%0d m%0d v%h",
                                     d, n, rv_q[k].c, rv_q[k].m, rv_q[k].v, exp_e.c, exp_e.m, exp_e.v);
                        end
                    end
                    n++;
                end
            end
            checks++;
            if (n != 8) begin
                errors++;
                $display("FAIL contend_count dut%0d: got %0d want 8", d, n);
            end
        end
    endtask

    task automatic test_stall();
        // Per cycle c0..c6: stall, expected {gnt0,gnt1}, expected strobe address (0 = none)
        logic        st_v  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  gnt_v [7] = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        logic [31:0] ra_v  [7] = '{32'h0, 32'h8, 32'h8, 32'h8, 32'h8, 32'h24, 32'h34};
        int          c0;
        int          ec [3];
        int          em [3] = '{0, 1, 0};
        logic [31:0] ed [3];
        ev_t         exp_e;
        pulse_reset();
        ed[0] = ref_mem[2];
        ed[1] = ref_mem[9];
        ed[2] = ref_mem[13];
        m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h8;
        m_req[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h24;
        c0 = 0;
        for (int t = 0; t < 7; t++) begin
            stall = st_v[t];
            if (t == 1) m_addr[0] = 32'h34;
            if (t == 5) m_req[1] = 1'b0;
            if (t == 6) m_req[0] = 1'b0;
            sample();
            if (t == 0) c0 = cyc;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if ({gnt_a[d][0], gnt_a[d][1]} !== gnt_v[t]) begin
                    errors++;
                    $display("FAIL stall_gnt dut%0d t%0d: got %b want %b", d, t,
                             {gnt_a[d][0], gnt_a[d][1]}, gnt_v[t]);
                end
                if (t > 0) begin
                    checks++;
                    if ({rreq_a[d], wreq_a[d], raddr_a[d]} !== {2'b10, ra_v[t]}) begin
                        errors++;
                        $display("FAIL stall_strobe dut%0d t%0d: got r%b w%b a%h want r1 w0 a%h",
                                 d, t, rreq_a[d], wreq_a[d], raddr_a[d], ra_v[t]);
                    end
                end
            end
            next_cycle();
        end
        stall = 1'b0;
        idle(6);
        // A was due at c0+1+lat without the stall; three frozen cycles push it to c0+4+lat.
        for (int d = 0; d < 2; d++) begin
            int n;
            n = 0;
            ec[0] = c0 + 4 + lat_of(d);
            ec[1] = c0 + 5 + lat_of(d);
            ec[2] = c0 + 6 + lat_of(d);
            foreach (rv_q[k]) begin
                if (rv_q[k].d == d) begin
                    if (n < 3) begin
                        exp_e.d = d; exp_e.c = ec[n]; exp_e.m = em[n]; exp_e.v = ed[n];
                        checks++;
                        if (rv_q[k] !== exp_e) begin
                            errors++;
                            $display("FAIL stall_rd dut%0d #%0d: got c%0d m%0d v%h want c%0d m%0d v%h",
                                     d, n, rv_q[k].c, rv_q[k].m, rv_q[k].v, exp_e.c, exp_e.m, exp_e.v);
                        end
                    end
                    n++;
                end
            end
            checks++;
            if (n != 3) begin
                errors++;
                $display("FAIL stall_count dut%0d: got %0d want 3", d, n);
            end
        end
    endtask

    task automatic test_mixed();
        int  c1;
        ev_t exp_e;
        pulse_reset();
        m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 32'h4; m_wdata[0] = 32'h0000_BEEF;
        m_wsel[0] = 4'hF;
        m_req[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h4;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({gnt_a[d][0], gnt_a[d][1]} !== 2'b10) begin
                errors++;
                $display("FAIL mixed_gnt0 dut%0d: got %b want 10", d, {gnt_a[d][0], gnt_a[d][1]});
            end
        end
        next_cycle();
        m_req[0] = 1'b0;
        ref_mem[1] = 32'h0000_BEEF;
        sample();
        c1 = cyc;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({gnt_a[d][0], gnt_a[d][1]} !== 2'b01) begin
                errors++;
                $display("FAIL mixed_gnt1 dut%0d: got %b want 01", d, {gnt_a[d][0], gnt_a[d][1]});
            end
            checks++;
            if ({wreq_a[d], rreq_a[d], waddr_a[d], wdata_a[d], wsel_a[d]} !==
                {2'b10, 32'h4, 32'h0000_BEEF, 4'hF}) begin
                errors++;
                $display("FAIL mixed_wr dut%0d: got w%b r%b a%h d%h s%h want w1 r0 a4 dbeef sf", d,
                         wreq_a[d], rreq_a[d], waddr_a[d], wdata_a[d], wsel_a[d]);
            end
        end
        next_cycle();
        m_req[1] = 1'b0;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({wreq_a[d], rreq_a[d], raddr_a[d]} !== {2'b01, 32'h4}) begin
                errors++;
                $display("FAIL mixed_rd_strobe dut%0d: got w%b r%b a%h want w0 r1 a4", d,
                         wreq_a[d], rreq_a[d], raddr_a[d]);
            end
        end
        next_cycle();
        idle(6);
        for (int d = 0; d < 2; d++) begin
            exp_e.d = d; exp_e.c = c1 + 1 + lat_of(d); exp_e.m = 1; exp_e.v = 32'h0000_BEEF;
            checks++;
            if (rv_q.size() != 2 || rv_q[d] !== exp_e) begin
                errors++;
                $display("FAIL mixed_rd dut%0d: got %0d events, first c%0d m%0d v%h want c%0d m1 vbeef",
                         d, rv_q.size(), (rv_q.size() > d) ? rv_q[d].c : -1,
                         (rv_q.size() > d) ? rv_q[d].m : -1,
                         (rv_q.size() > d) ? rv_q[d].v : 32'h0, exp_e.c);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int  c3;
        ev_t exp_e;
        rv_q.delete();
        m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h14;
        sample();
        next_cycle();
        m_req[0] = 1'b0;
        rst = 1'b0;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({rreq_a[d], raddr_a[d], gnt_a[d][0], gnt_a[d][1]} !== {1'b1, 32'h14, 2'b00}) begin
                errors++;
                $display("FAIL midrst_strobe dut%0d: got r%b a%h g%b%b want r1 a14 g00", d,
                         rreq_a[d], raddr_a[d], gnt_a[d][0], gnt_a[d][1]);
            end
        end
        next_cycle();
        rst = 1'b1;
        sample();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({rreq_a[d], wreq_a[d], raddr_a[d], rv_a[d][0], rv_a[d][1]} !== 36'h0) begin
                errors++;
                $display("FAIL midrst_clear dut%0d: got r%b w%b a%h rv%b%b want all 0", d,
                         rreq_a[d], wreq_a[d], raddr_a[d], rv_a[d][0], rv_a[d][1]);
            end
        end
        next_cycle();
        m_req[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 32'h18;
        sample();
        c3 = cyc;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({gnt_a[d][0], gnt_a[d][1]} !== 2'b01) begin
                errors++;
                $display("FAIL midrst_gnt dut%0d: got %b want 01", d, {gnt_a[d][0], gnt_a[d][1]});
            end
        end
        next_cycle();
        idle(6);
        for (int d = 0; d < 2; d++) begin
            exp_e.d = d; exp_e.c = c3 + 1 + lat_of(d); exp_e.m = 1; exp_e.v = ref_mem[6];
            checks++;
            if (rv_q.size() != 2 || rv_q[d] !== exp_e) begin
                errors++;
                $display("FAIL midrst_rd dut%0d: got %0d events, c%0d m%0d v%h want 2 events c%0d m1 v%h",
                         d, rv_q.size(), (rv_q.size() > d) ? rv_q[d].c : -1,
                         (rv_q.size() > d) ? rv_q[d].m : -1,
                         (rv_q.size() > d) ? rv_q[d].v : 32'h0, exp_e.c, exp_e.v);
            end
        end
    endtask

    initial begin
        wreq_cnt[0] = 0;
        wreq_cnt[1] = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_single_master();
        test_contention();
        test_stall();
        test_mixed();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
